// File: rtl/aes_axi_stream_master.sv
// AES output stage: buffers 128-bit result blocks in a FIFO and serializes each
// block into four 32-bit AXI4-Stream beats, pulsing axis_master_done after tlast.
module aes_axi_stream_master #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_SIZE            = 16,
    parameter int FIFO_ADDR_WIDTH      = 4,
    parameter int FIFO_DATA_WIDTH      = 128
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_areset,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    input  logic                                out_fifo_write_tvalid,
    output logic                                out_fifo_write_tready,
    input  logic [FIFO_DATA_WIDTH-1:0]          out_fifo_wdata,
    input  logic                                out_fifo_wlast,
    output logic                                out_fifo_almost_full,
    output logic                                out_fifo_empty,
    output logic                                out_fifo_full,
    output logic                                axis_master_done
);

    localparam logic [FIFO_ADDR_WIDTH-1:0] L_PTR_ONE = (FIFO_ADDR_WIDTH)'(1);
    localparam logic [FIFO_ADDR_WIDTH:0]   L_CNT_ONE = (FIFO_ADDR_WIDTH+1)'(1);
    localparam logic [FIFO_ADDR_WIDTH:0]   L_FULL    = (FIFO_ADDR_WIDTH+1)'(FIFO_SIZE);
    localparam logic [FIFO_ADDR_WIDTH:0]   L_AFULL   = (FIFO_ADDR_WIDTH+1)'(FIFO_SIZE-1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    logic [FIFO_DATA_WIDTH:0]     r_mem [FIFO_SIZE];
    logic [FIFO_ADDR_WIDTH-1:0]   r_wptr, r_rptr;
    logic [FIFO_ADDR_WIDTH:0]     r_count, w_count_nxt;
    logic                         r_empty, r_full, r_afull;
    logic [FIFO_DATA_WIDTH-1:0]   r_shreg;
    logic                         r_last;
    logic [1:0]                   r_wcnt;
    logic                         r_tvalid;
    state_t                       r_state, w_state_nxt;
    logic                         w_wr, w_pop, w_beat, w_last_word;
    logic [FIFO_DATA_WIDTH:0]     w_rd_entry;

    assign w_wr        = out_fifo_write_tvalid && !r_full;
    assign w_beat      = r_tvalid && m00_axis_tready;
    assign w_last_word = (r_wcnt == 2'd3);
    assign w_rd_entry  = r_mem[r_rptr];

    always_ff @(posedge m00_axis_aclk) begin
        if (w_wr) r_mem[r_wptr] <= {out_fifo_wlast, out_fifo_wdata};
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + L_CNT_ONE;
            2'b01:   w_count_nxt = r_count - L_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are registered from the next count so they track the count register exactly.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + L_PTR_ONE;
            if (w_pop) r_rptr <= r_rptr + L_PTR_ONE;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == L_FULL);
            r_afull <= (w_count_nxt >= L_AFULL);
        end
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) r_state <= S_IDLE;
        else                 r_state <= w_state_nxt;
    end

    // Popping uses the registered empty flag, so a freshly written block waits a cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_beat && w_last_word) begin
                    if (r_last)        w_state_nxt = S_DONE;
                    else if (!r_empty) w_pop       = 1'b1;
                    else               w_state_nxt = S_IDLE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            r_shreg  <= '0;
            r_last   <= 1'b0;
            r_wcnt   <= 2'd0;
            r_tvalid <= 1'b0;
        end else if (w_pop) begin
            r_shreg  <= w_rd_entry[FIFO_DATA_WIDTH-1:0];
            r_last   <= w_rd_entry[FIFO_DATA_WIDTH];
            r_wcnt   <= 2'd0;
            r_tvalid <= 1'b1;
        end else if (w_beat) begin
            r_shreg  <= {{C_M_AXIS_TDATA_WIDTH{1'b0}},
                         r_shreg[FIFO_DATA_WIDTH-1:C_M_AXIS_TDATA_WIDTH]};
            r_wcnt   <= r_wcnt + 2'd1;
            if (w_last_word) r_tvalid <= 1'b0;
        end
    end

    assign m00_axis_tvalid       = r_tvalid;
    assign m00_axis_tdata        = r_shreg[C_M_AXIS_TDATA_WIDTH-1:0];
    assign m00_axis_tstrb        = '1;
    assign m00_axis_tlast        = (r_state == S_STREAM) && r_last && w_last_word;
    assign axis_master_done      = (r_state == S_DONE);
    assign out_fifo_write_tready = !r_full;
    assign out_fifo_almost_full  = r_afull;
    assign out_fifo_empty        = r_empty;
    assign out_fifo_full         = r_full;

endmodule

// File: tb/tb_aes_axi_stream_master.sv
// Bench for aes_axi_stream_master: blocks are expanded into an expected beat list
// and compared against beats observed on the stream side.
module tb_aes_axi_stream_master;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tvalid, tready, tlast, wr_rdy, af, emp, ful, done, wv, wl;
    logic [31:0]  tdata;
    logic [3:0]   tstrb;
    logic [127:0] wd;

    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] expq[$];
    logic [32:0] obsq[$];
    int   done_cnt = 0;
    int   done_bad = 0;
    logic tlast_acc_d = 1'b0;

    always #5 clk = ~clk;

    aes_axi_stream_master dut (
        .m00_axis_aclk         (clk),
        .m00_axis_areset       (rst),
        .m00_axis_tvalid       (tvalid),
        .m00_axis_tready       (tready),
        .m00_axis_tdata        (tdata),
        .m00_axis_tstrb        (tstrb),
        .m00_axis_tlast        (tlast),
        .out_fifo_write_tvalid (wv),
        .out_fifo_write_tready (wr_rdy),
        .out_fifo_wdata        (wd),
        .out_fifo_wlast        (wl),
        .out_fifo_almost_full  (af),
        .out_fifo_empty        (emp),
        .out_fifo_full         (ful),
        .axis_master_done      (done)
    );

    // Reference: every accepted block becomes four little-end-first words, tlast on the
    // fourth word of a block flagged last; done must follow an accepted tlast by one cycle.
    always @(posedge clk) begin
        if (rst) begin
            tlast_acc_d <= 1'b0;
        end else begin
            if (wv && wr_rdy)
                for (int k = 0; k < 4; k++) expq.push_back({wl && (k == 3), wd[32*k +: 32]});
            if (tvalid && tready) obsq.push_back({tlast, tdata});
            if (done) done_cnt <= done_cnt + 1;
            if (done !== tlast_acc_d) done_bad <= done_bad + 1;
            tlast_acc_d <= tvalid && tready && tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int qdiff();
        int d;
        d = (obsq.size() > expq.size()) ? obsq.size() - expq.size() : expq.size() - obsq.size();
        for (int i = 0; i < obsq.size() && i < expq.size(); i++)
            if (obsq[i] !== expq[i]) d++;
        return d;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drain(input int maxc, output bit tmo);
        int c;
        c = 0;
        tready = 1'b1;
        wv = 1'b0;
        wl = 1'b0;
        while (c < maxc && !(obsq.size() >= expq.size() && !tvalid && emp)) begin
            @(negedge clk);
            c++;
        end
        tmo = (c >= maxc);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; tready = 1'b0; wv = 1'b0; wl = 1'b0; wd = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tvalid, tdata, tlast, done} !== 35'h0)
            $display("FAIL reset_stream: got %h expected 0", {tvalid, tdata, tlast, done});
        else n_pass++;
        n_checks++;
        if ({emp, ful, af, wr_rdy} !== 4'b1001)
            $display("FAIL reset_flags: got %b expected 1001", {emp, ful, af, wr_rdy});
        else n_pass++;
        n_checks++;
        if (tstrb !== 4'hF) $display("FAIL reset_tstrb: got %h expected f", tstrb);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tvalid, emp} !== 2'b01) $display("FAIL idle_after_release: got %b expected 01", {tvalid, emp});
        else n_pass++;
    endtask

    task automatic test_single();
        int d0;
        logic [31:0] w;
        d0 = done_cnt;
        obsq.delete(); expq.delete();
        @(negedge clk);
        tready = 1'b1; wv = 1'b1; wl = 1'b1;
        wd = 128'h33333333_22222222_11111111_00000000;
        @(negedge clk);
        wv = 1'b0; wl = 1'b0;
        n_checks++;
        if ({emp, tvalid} !== 2'b00) $display("FAIL single_latency: got %b expected 00", {emp, tvalid});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            w = 32'(i) * 32'h11111111;
            n_checks++;
            if ({tvalid, tlast, tdata} !== {1'b1, (i == 3), w})
                $display("FAIL single_beat%0d: got %h expected %h", i, {tvalid, tlast, tdata}, {1'b1, (i == 3), w});
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({done, tvalid} !== 2'b10) $display("FAIL single_done: got %b expected 10", {done, tvalid});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, emp} !== 2'b01) $display("FAIL single_after_done: got %b expected 01", {done, emp});
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== 1) $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0, gaps, seen, nl;
        bit tmo;
        d0 = done_cnt; gaps = 0; seen = 0; nl = 0;
        obsq.delete(); expq.delete();
        tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tvalid) seen++;
            else if (seen > 0 && seen < 12) gaps++;
            if (c < 3) begin wv = 1'b1; wl = (c == 2); wd = rnd128(); end
            else begin wv = 1'b0; wl = 1'b0; end
            if (seen == 12) break;
        end
        drain(60, tmo);
        for (int i = 0; i < obsq.size(); i++) if (obsq[i][32]) nl++;
        n_checks++;
        if (tmo || gaps != 0 || seen != 12)
            $display("FAIL b2b_contiguous: got gaps=%0d beats=%0d tmo=%0d expected 0/12/0", gaps, seen, tmo);
        else n_pass++;
        n_checks++;
        if (qdiff() != 0 || expq.size() != 12)
            $display("FAIL b2b_data: got %0d diffs expected 0", qdiff());
        else n_pass++;
        n_checks++;
        if (nl != 1 || obsq[11][32] !== 1'b1) $display("FAIL b2b_tlast: got %0d tlast beats expected 1 on beat 11", nl);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL b2b_done_count: got %0d expected 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int d0, hold_bad, stalls;
        bit prev_stall, lflag;
        logic [33:0] prev;
        logic [3:0] pat;
        d0 = done_cnt; hold_bad = 0; stalls = 0; prev_stall = 1'b0; prev = '0;
        pat = 4'b1001;
        lflag = 1'($urandom() % 2);
        obsq.delete(); expq.delete();
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 0) begin wv = 1'b1; wl = lflag; wd = rnd128(); end
            else begin wv = 1'b0; wl = 1'b0; end
            if (prev_stall && ({tvalid, tlast, tdata} !== prev)) hold_bad++;
            tready = pat[c % 4];
            prev_stall = tvalid && !tready;
            if (prev_stall) stalls++;
            prev = {tvalid, tlast, tdata};
            if (obsq.size() == 4 && !tvalid) break;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (hold_bad != 0 || stalls == 0)
            $display("FAIL bp_hold: got %0d changes during %0d stalls expected 0 changes", hold_bad, stalls);
        else n_pass++;
        n_checks++;
        if (qdiff() != 0 || obsq.size() != 4) $display("FAIL bp_data: got %0d diffs expected 0", qdiff());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != int'(lflag)) $display("FAIL bp_done: got %0d expected %0d", done_cnt - d0, lflag);
        else n_pass++;
    endtask

    task automatic test_full();
        int d0, acc, cnt;
        bit tmo;
        d0 = done_cnt; acc = 0;
        obsq.delete(); expq.delete();
        tready = 1'b0;
        // One block sits in the serializer, so the FIFO itself holds all but the first.
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k > 1) begin
                cnt = (acc <= 1) ? acc : acc - 1;
                n_checks++;
                if ({af, ful, wr_rdy} !== {cnt >= 15, cnt == 16, cnt != 16})
                    $display("FAIL fill_flags_%0d: got %b expected %b", acc, {af, ful, wr_rdy}, {cnt >= 15, cnt == 16, cnt != 16});
                else n_pass++;
            end
            if (wr_rdy) acc++;
            wv = 1'b1; wl = (k == 17); wd = rnd128();
        end
        @(negedge clk);
        wv = 1'b0; wl = 1'b0;
        n_checks++;
        if ({af, ful, wr_rdy} !== 3'b110) $display("FAIL full_flags: got %b expected 110", {af, ful, wr_rdy});
        else n_pass++;
        n_checks++;
        if (acc != 17 || expq.size() != 68) $display("FAIL full_accepts: got %0d blocks expected 17", acc);
        else n_pass++;
        drain(300, tmo);
        n_checks++;
        if (tmo || qdiff() != 0) $display("FAIL full_drain: got %0d diffs tmo=%0d expected 0", qdiff(), tmo);
        else n_pass++;
        n_checks++;
        if ({done_cnt - d0, emp, ful} !== {32'd1, 1'b1, 1'b0})
            $display("FAIL full_end: got done=%0d emp=%b expected 1/1", done_cnt - d0, emp);
        else n_pass++;
    endtask

    task automatic test_simul();
        int d0;
        bit tmo;
        logic [127:0] a, b, c;
        d0 = done_cnt;
        a = rnd128(); b = rnd128(); c = rnd128();
        obsq.delete(); expq.delete();
        tready = 1'b1;
        @(negedge clk); wv = 1'b1; wl = 1'b0; wd = a;
        @(negedge clk); wv = 1'b0;
        @(negedge clk); wv = 1'b1; wd = b;
        @(negedge clk); wv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({tvalid, tdata, emp, ful, af} !== {1'b1, a[127:96], 3'b000})
            $display("FAIL simul_before: got %h expected %h", {tvalid, tdata, emp, ful, af}, {1'b1, a[127:96], 3'b000});
        else n_pass++;
        wv = 1'b1; wl = 1'b1; wd = c;
        @(negedge clk);
        wv = 1'b0; wl = 1'b0;
        n_checks++;
        if ({emp, ful, af, wr_rdy} !== 4'b0001) $display("FAIL simul_flags: got %b expected 0001", {emp, ful, af, wr_rdy});
        else n_pass++;
        n_checks++;
        if ({tvalid, tdata} !== {1'b1, b[31:0]}) $display("FAIL simul_no_bubble: got %h expected %h", {tvalid, tdata}, {1'b1, b[31:0]});
        else n_pass++;
        drain(60, tmo);
        n_checks++;
        if (tmo || qdiff() != 0 || expq.size() != 12) $display("FAIL simul_data: got %0d diffs expected 0", qdiff());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL simul_done: got %0d expected 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0;
        bit tmo;
        logic [127:0] a;
        a = rnd128();
        obsq.delete(); expq.delete();
        tready = 1'b1;
        @(negedge clk); wv = 1'b1; wl = 1'b1; wd = a;
        @(negedge clk); wv = 1'b0; wl = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tvalid, tdata} !== {1'b1, a[95:64]}) $display("FAIL rstmid_align: got %h expected %h", {tvalid, tdata}, {1'b1, a[95:64]});
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({tvalid, tlast, emp, done} !== 4'b0010) $display("FAIL rstmid_async: got %b expected 0010", {tvalid, tlast, emp, done});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        obsq.delete(); expq.delete();
        d0 = done_cnt;
        a = rnd128();
        @(negedge clk); wv = 1'b1; wl = 1'b1; wd = a;
        @(negedge clk); wv = 1'b0; wl = 1'b0;
        drain(60, tmo);
        n_checks++;
        if (tmo || qdiff() != 0 || obsq.size() != 4 || obsq[0] !== {1'b0, a[31:0]})
            $display("FAIL rstmid_restart: got %0d diffs size %0d expected 0/4", qdiff(), obsq.size());
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL rstmid_done: got %0d expected 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_random();
        int d0, npk, bad0, nb, g;
        bit tmo, wdone;
        d0 = done_cnt; npk = 0; bad0 = done_bad; wdone = 1'b0;
        obsq.delete(); expq.delete();
        fork
            begin
                for (int p = 0; p < 6; p++) begin
                    nb = $urandom_range(1, 4);
                    for (int b = 0; b < nb; b++) begin
                        g = 0;
                        @(negedge clk); wv = 1'b1; wl = (b == nb - 1); wd = rnd128();
                        while (!wr_rdy && g < 300) begin @(negedge clk); g++; end
                        if ($urandom() % 3 == 0) begin @(negedge clk); wv = 1'b0; wl = 1'b0; end
                    end
                    npk++;
                end
                @(negedge clk); wv = 1'b0; wl = 1'b0;
                wdone = 1'b1;
            end
            begin
                while (!wdone) begin
                    @(negedge clk);
                    tready = ($urandom() % 4) != 0;
                end
            end
        join
        drain(600, tmo);
        n_checks++;
        if (tmo || qdiff() != 0 || expq.size() == 0)
            $display("FAIL rand_data: got %0d diffs of %0d beats tmo=%0d expected 0", qdiff(), expq.size(), tmo);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != npk) $display("FAIL rand_done: got %0d expected %0d", done_cnt - d0, npk);
        else n_pass++;
        n_checks++;
        if (done_bad != bad0) $display("FAIL rand_done_timing: got %0d misplaced expected 0", done_bad - bad0);
        else n_pass++;
    endtask

    initial begin
        tready = 1'b0; wv = 1'b0; wl = 1'b0; wd = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full();
        test_simul();
        test_reset_mid();
        test_random();
        n_checks++;
        if (done_bad != 0) $display("FAIL done_follows_tlast: got %0d misplaced pulses expected 0", done_bad);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
